// File: rtl/seq_norm_pkg.sv
// Shared types and helpers for the iterative leading-zero normalizer.
package seq_norm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lead_one_enc.sv
// Priority encoder: number of zeros above the first one in a step-bit window.
module lead_one_enc #(
    parameter int unsigned step = 4,
    localparam int unsigned PosW = (step > 1) ? $clog2(step) : 1
) (
    input  logic [step-1:0] i_win,
    output logic [PosW-1:0] o_pos,
    output logic            o_any
);

    always_comb begin
        o_pos = '0;
        o_any = |i_win;
        // Ascending scan so the highest set bit wins.
        for (int i = 0; i < int'(step); i++) begin
            if (i_win[i]) begin
                o_pos = PosW'(int'(step) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/seq_lead_zero_norm.sv
// Iterative leading-zero counter/normalizer: shifts the operand left by up to
// step bits per cycle until its MSB is set, then holds the result until taken.
module seq_lead_zero_norm
    import seq_norm_pkg::*;
#(
    parameter int unsigned width = 32,
    parameter int unsigned step  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [width-1:0]             A_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [width-1:0]             Norm_o,
    output logic [cnt_width(width)-1:0]  Cnt_o,
    output logic                         Zero_o
);

    localparam int unsigned CntW = cnt_width(width);
    localparam int unsigned PosW = (step > 1) ? $clog2(step) : 1;

    if ((width % step) != 0 || (step & (step - 1)) != 0 || step > width || step == 0) begin : g_bad
        $fatal(1, "seq_lead_zero_norm: step must be a power of 2 dividing width");
    end

    state_e            r_state;
    logic [width-1:0]  r_sh;
    logic [CntW-1:0]   r_cnt;
    logic              r_zero;
    logic              r_valid;
    logic              r_ready;

    logic [PosW-1:0]   w_pos;
    logic              w_any;

    lead_one_enc #(
        .step (step)
    ) u_enc (
        .i_win (r_sh[width-1 -: step]),
        .o_pos (w_pos),
        .o_any (w_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (valid_i && r_ready) begin
                        r_sh    <= A_i;
                        r_ready <= 1'b0;
                        if (A_i == '0) begin
                            r_state <= DONE;
                            r_zero  <= 1'b1;
                            r_cnt   <= CntW'(width);
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                            r_zero  <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (!w_any) begin
                        r_sh  <= r_sh << step;
                        r_cnt <= r_cnt + CntW'(step);
                    end else begin
                        r_sh    <= r_sh << w_pos;
                        r_cnt   <= r_cnt + CntW'(w_pos);
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign Norm_o  = r_sh;
    assign Cnt_o   = r_cnt;
    assign Zero_o  = r_zero;

endmodule

// File: tb/tb_seq_lead_zero_norm.sv
// Directed-vector bench for seq_lead_zero_norm (width=32, step=4).
module tb_seq_lead_zero_norm;

    localparam int unsigned Width = 32;
    localparam int unsigned Step  = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [Width-1:0]  A_i = '0;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [Width-1:0]  Norm_o;
    logic [5:0]        Cnt_o;
    logic              Zero_o;

    int n_chk  = 0;
    int n_pass = 0;

    seq_lead_zero_norm #(
        .width (Width),
        .step  (Step)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .A_i     (A_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .Norm_o  (Norm_o),
        .Cnt_o   (Cnt_o),
        .Zero_o  (Zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Accept one operand, measure edges until valid_o is seen, check result, then drain.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] e_norm,
                          input int e_cnt, input logic e_zero, input int e_lat);
        int n;
        n = 0;
        while (!ready_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1;
        A_i     = a;
        tick();
        valid_i = 1'b0;
        A_i     = '0;
        n = 0;
        while (!valid_o && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n + 1), 64'(e_lat));
        chk({tag, "_norm"}, 64'(Norm_o), 64'(e_norm));
        chk({tag, "_cnt"}, 64'(Cnt_o), 64'(e_cnt));
        chk({tag, "_zero"}, 64'(Zero_o), 64'(e_zero));
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk({tag, "_vdrop"}, 64'(valid_o), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_norm", 64'(Norm_o), 64'd0);
        chk("rst_cnt", 64'(Cnt_o), 64'd0);
        chk("rst_zero", 64'(Zero_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_ready", 64'(ready_o), 64'd1);

        run_op("zero", 32'h0000_0000, 32'h0000_0000, 32, 1'b1, 1);
        run_op("msb",  32'h8000_0000, 32'h8000_0000, 0,  1'b0, 2);
        run_op("mid",  32'h0001_2345, 32'h91A2_8000, 15, 1'b0, 5);
        run_op("one",  32'h0000_0001, 32'h8000_0000, 31, 1'b0, 9);
        run_op("nib",  32'h0800_0000, 32'h8000_0000, 4,  1'b0, 3);
        run_op("full", 32'hF000_000F, 32'hF000_000F, 0,  1'b0, 2);

        // Backpressure: result holds while ready_i=0; new operands are ignored.
        begin
            int n;
            valid_i = 1'b1;
            A_i     = 32'h0001_2345;
            tick();
            valid_i = 1'b0;
            n = 0;
            while (!valid_o && n < 40) begin
                tick();
                n++;
            end
            chk("bp_lat", 64'(n + 1), 64'd5);
            for (int i = 0; i < 5; i++) begin
                valid_i = 1'b1;
                A_i     = 32'h0000_00FF;
                tick();
            end
            valid_i = 1'b0;
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_ready", 64'(ready_o), 64'd0);
            chk("bp_norm", 64'(Norm_o), 64'h91A2_8000);
            chk("bp_cnt", 64'(Cnt_o), 64'd15);
            chk("bp_zero", 64'(Zero_o), 64'd0);
            ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
            chk("bp_exit_valid", 64'(valid_o), 64'd0);
            chk("bp_exit_ready", 64'(ready_o), 64'd1);
            chk("bp_not_captured", 64'(Norm_o), 64'h91A2_8000);
        end

        // Asynchronous reset while shifting.
        valid_i = 1'b1;
        A_i     = 32'h0000_0001;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        tick();
        chk("ms_busy", 64'(ready_o), 64'd0);
        rst_ni = 1'b0;
        #1;
        chk("ms_rst_norm", 64'(Norm_o), 64'd0);
        chk("ms_rst_cnt", 64'(Cnt_o), 64'd0);
        chk("ms_rst_valid", 64'(valid_o), 64'd0);
        chk("ms_rst_ready", 64'(ready_o), 64'd0);
        #2;
        rst_ni = 1'b1;
        tick();
        chk("ms_post_ready", 64'(ready_o), 64'd1);
        run_op("after", 32'h0000_0010, 32'h8000_0000, 27, 1'b0, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
